// File: rtl/port_serial_tx.sv
// Port-mapped serial transmitter: IN/OUT port responder feeding a small TX FIFO
// that a baud-divided shifter drains as 8N1 frames on a one-wire line.
module port_serial_tx #(
   parameter int                   WORD_SIZE   = 16,
   parameter logic [WORD_SIZE-1:0] BASE_ADDR   = 16'h0010,
   parameter int                   FIFO_DEPTH  = 4,
   parameter logic [WORD_SIZE-1:0] DEFAULT_DIV = 16'd9
) (
   input  logic                 clk,
   input  logic                 do_reset,
   input  logic [WORD_SIZE-1:0] portaddr,
   input  logic [WORD_SIZE-1:0] portval,
   input  logic                 portget,
   input  logic                 portset,
   output logic [WORD_SIZE-1:0] portout,
   output logic                 tx,
   output logic                 tx_busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [WORD_SIZE-1:0] ADDR_DATA   = BASE_ADDR;
   localparam logic [WORD_SIZE-1:0] ADDR_STATUS = BASE_ADDR + WORD_SIZE'(1);
   localparam logic [WORD_SIZE-1:0] ADDR_DIV    = BASE_ADDR + WORD_SIZE'(2);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [7:0]           r_mem [FIFO_DEPTH];
   logic [PW-1:0]        r_wr_ptr;
   logic [PW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;
   logic                 r_overflow;
   logic [WORD_SIZE-1:0] r_div;
   logic [WORD_SIZE-1:0] r_reload;
   logic [WORD_SIZE-1:0] r_timer;
   logic [2:0]           r_bitcnt;
   logic [7:0]           r_shift;
   logic                 r_tx;
   logic                 r_busy;
   logic [WORD_SIZE-1:0] r_portout;

   logic                 w_hit_data;
   logic                 w_hit_status;
   logic                 w_hit_div;
   logic                 w_push;
   logic                 w_push_ok;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_shift_en;
   logic [WORD_SIZE-1:0] w_status;
   logic [WORD_SIZE-1:0] w_reload_next;
   logic [WORD_SIZE-1:0] w_timer_next;
   logic [2:0]           w_bitcnt_next;
   logic                 w_tx_next;
   logic                 w_busy_next;

   assign w_hit_data   = (portaddr == ADDR_DATA);
   assign w_hit_status = (portaddr == ADDR_STATUS);
   assign w_hit_div    = (portaddr == ADDR_DIV);
   assign w_full       = (r_count == CW'(FIFO_DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_push       = portset && w_hit_data;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign w_push_ok    = w_push && (!w_full || w_pop);

   assign portout = r_portout;
   assign tx      = r_tx;
   assign tx_busy = r_busy;

   always_comb begin
      w_status      = '0;
      w_status[0]   = r_busy;
      w_status[1]   = w_full;
      w_status[2]   = w_empty;
      w_status[3]   = r_overflow;
      w_status[8:4] = 5'(r_count);
   end

   always_comb begin
      w_state_next  = r_state;
      w_pop         = 1'b0;
      w_shift_en    = 1'b0;
      w_reload_next = r_reload;
      w_timer_next  = r_timer;
      w_bitcnt_next = r_bitcnt;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop         = 1'b1;
               w_reload_next = r_div;
               w_timer_next  = r_div;
               w_state_next  = S_START;
            end
         end
         S_START: begin
            if (r_timer == '0) begin
               w_timer_next  = r_reload;
               w_bitcnt_next = 3'd0;
               w_state_next  = S_DATA;
            end else begin
               w_timer_next = r_timer - WORD_SIZE'(1);
            end
         end
         S_DATA: begin
            if (r_timer == '0) begin
               w_timer_next = r_reload;
               w_shift_en   = 1'b1;
               if (r_bitcnt == 3'd7) begin
                  w_state_next = S_STOP;
               end else begin
                  w_bitcnt_next = r_bitcnt + 3'd1;
               end
            end else begin
               w_timer_next = r_timer - WORD_SIZE'(1);
            end
         end
         S_STOP: begin
            if (r_timer == '0) begin
               // Chain straight into the next frame when data is waiting.
               if (!w_empty) begin
                  w_pop         = 1'b1;
                  w_reload_next = r_div;
                  w_timer_next  = r_div;
                  w_state_next  = S_START;
               end else begin
                  w_state_next = S_IDLE;
               end
            end else begin
               w_timer_next = r_timer - WORD_SIZE'(1);
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      case (w_state_next)
         S_START: w_tx_next = 1'b0;
         S_DATA:  w_tx_next = w_shift_en ? r_shift[1] : r_shift[0];
         default: w_tx_next = 1'b1;
      endcase
      w_busy_next = (w_state_next != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= portval[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (do_reset) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_div      <= DEFAULT_DIV;
         r_reload   <= DEFAULT_DIV;
         r_timer    <= '0;
         r_bitcnt   <= 3'd0;
         r_shift    <= 8'h00;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_portout  <= '0;
      end else begin
         r_state  <= w_state_next;
         r_reload <= w_reload_next;
         r_timer  <= w_timer_next;
         r_bitcnt <= w_bitcnt_next;
         r_tx     <= w_tx_next;
         r_busy   <= w_busy_next;
         if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
         end else if (w_shift_en) begin
            r_shift <= {1'b0, r_shift[7:1]};
         end
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
         // A fresh drop wins over a simultaneous STATUS read clearing the flag.
         if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end else if (portget && w_hit_status) begin
            r_overflow <= 1'b0;
         end
         if (portset && w_hit_div) begin
            r_div <= portval;
         end
         if (portget) begin
            if (w_hit_data) begin
               r_portout <= '0;
            end else if (w_hit_status) begin
               r_portout <= w_status;
            end else if (w_hit_div) begin
               r_portout <= r_div;
            end
         end
      end
   end

endmodule

// File: tb/tb_port_serial_tx.sv
// Directed bench for port_serial_tx: port reads/writes, frame bit timing,
// back-to-back frames, FIFO overflow, address decode and mid-frame reset.
module tb_port_serial_tx;

   logic        clk;
   logic        do_reset;
   logic [15:0] portaddr;
   logic [15:0] portval;
   logic        portget;
   logic        portset;
   logic [15:0] portout;
   logic        tx;
   logic        tx_busy;

   int n_checks;
   int n_fail;

   port_serial_tx dut (
      .clk      (clk),
      .do_reset (do_reset),
      .portaddr (portaddr),
      .portval  (portval),
      .portget  (portget),
      .portset  (portset),
      .portout  (portout),
      .tx       (tx),
      .tx_busy  (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [15:0] addr, input logic [15:0] val);
      portaddr = addr;
      portval  = val;
      portset  = 1'b1;
      tick();
      portset  = 1'b0;
      portaddr = 16'h0000;
      $display("OUT addr=%h val=%h", addr, val);
   endtask

   task automatic rd(input logic [15:0] addr);
      portaddr = addr;
      portget  = 1'b1;
      tick();
      portget  = 1'b0;
      portaddr = 16'h0000;
      $display("IN  addr=%h -> portout=%h", addr, portout);
   endtask

   task automatic rdwr(input logic [15:0] addr, input logic [15:0] val);
      portaddr = addr;
      portval  = val;
      portget  = 1'b1;
      portset  = 1'b1;
      tick();
      portget  = 1'b0;
      portset  = 1'b0;
      portaddr = 16'h0000;
      $display("IN+OUT addr=%h val=%h -> portout=%h", addr, val, portout);
   endtask

   initial begin
      logic [9:0] exp_a5;
      logic [7:0] frame_byte;
      logic       exp_tx;
      int         busy_cnt;
      int         b;

      n_checks = 0;
      n_fail   = 0;
      do_reset = 1'b1;
      portaddr = 16'h0000;
      portval  = 16'h0000;
      portget  = 1'b0;
      portset  = 1'b0;

      // Reset state and first STATUS read
      tick();
      tick();
      do_reset = 1'b0;
      chk("reset_tx", {15'd0, tx}, 16'h0001);
      chk("reset_busy", {15'd0, tx_busy}, 16'h0000);
      chk("reset_portout", portout, 16'h0000);
      rd(16'h0011);
      chk("reset_status", portout, 16'h0004);
      chk("reset_tx_idle", {15'd0, tx}, 16'h0001);

      // DIV=0, single byte 0xA5: one clock per bit
      wr(16'h0012, 16'h0000);
      wr(16'h0010, 16'h00A5);
      exp_a5   = 10'b1101001010;
      busy_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (tx_busy) busy_cnt++;
         if (i < 10) chk($sformatf("a5_bit%0d", i), {15'd0, tx}, {15'd0, exp_a5[i]});
      end
      chk("a5_busy_clocks", 16'(busy_cnt), 16'd10);
      chk("a5_tx_after", {15'd0, tx}, 16'h0001);

      // DIV=3, two back-to-back frames 0x01 then 0x80
      wr(16'h0012, 16'h0003);
      wr(16'h0010, 16'h0001);
      wr(16'h0010, 16'h0080);
      for (int s = 0; s <= 80; s++) begin
         if (s < 80) begin
            frame_byte = (s < 40) ? 8'h01 : 8'h80;
            b = (s % 40) / 4;
            if (b == 0)      exp_tx = 1'b0;
            else if (b == 9) exp_tx = 1'b1;
            else             exp_tx = frame_byte[b-1];
         end else begin
            exp_tx = 1'b1;
         end
         chk($sformatf("b2b_tx_s%0d", s), {15'd0, tx}, {15'd0, exp_tx});
         chk($sformatf("b2b_busy_s%0d", s), {15'd0, tx_busy}, (s < 80) ? 16'h0001 : 16'h0000);
         if (s == 6)  chk("b2b_status_count1", portout, 16'h0011);
         if (s == 46) chk("b2b_status_count0", portout, 16'h0005);
         portaddr = 16'h0011;
         portget  = (s == 5 || s == 45);
         tick();
      end
      portget  = 1'b0;
      portaddr = 16'h0000;

      // Overflow: long frame keeps the FIFO from draining
      wr(16'h0012, 16'd100);
      wr(16'h0010, 16'h0011);
      tick();
      for (int k = 0; k < 5; k++) wr(16'h0010, 16'h0021 + 16'(k));
      rd(16'h0011);
      chk("ovf_status_set", portout, 16'h004B);
      rd(16'h0010);
      chk("data_read_zero", portout, 16'h0000);
      rd(16'h0011);
      chk("ovf_status_cleared", portout, 16'h0043);

      // DIV register, unmapped address, simultaneous get/set
      wr(16'h0012, 16'h1234);
      rd(16'h0012);
      chk("div_readback", portout, 16'h1234);
      rdwr(16'h0013, 16'hFFFF);
      chk("unmapped_portout_hold", portout, 16'h1234);
      rd(16'h0012);
      chk("unmapped_div_kept", portout, 16'h1234);
      rd(16'h0011);
      chk("unmapped_status_kept", portout, 16'h0043);
      rdwr(16'h0012, 16'h0007);
      chk("getset_pre_write", portout, 16'h1234);
      rd(16'h0012);
      chk("getset_post_write", portout, 16'h0007);

      // Fresh start at default divisor, then reset mid data bit 4
      do_reset = 1'b1;
      tick();
      do_reset = 1'b0;
      chk("reset2_tx", {15'd0, tx}, 16'h0001);
      chk("reset2_busy", {15'd0, tx_busy}, 16'h0000);
      wr(16'h0010, 16'h000F);
      wr(16'h0010, 16'h005A);
      repeat (49) tick();
      chk("mid_bit3_tx", {15'd0, tx}, 16'h0001);
      repeat (3) tick();
      chk("mid_bit4_tx", {15'd0, tx}, 16'h0000);
      chk("mid_bit4_busy", {15'd0, tx_busy}, 16'h0001);
      do_reset = 1'b1;
      tick();
      do_reset = 1'b0;
      chk("abort_tx", {15'd0, tx}, 16'h0001);
      chk("abort_busy", {15'd0, tx_busy}, 16'h0000);
      rd(16'h0011);
      chk("abort_status_empty", portout, 16'h0004);
      rd(16'h0012);
      chk("abort_div_default", portout, 16'h0009);
      repeat (5) tick();
      chk("abort_stays_idle_tx", {15'd0, tx}, 16'h0001);
      chk("abort_stays_idle_busy", {15'd0, tx_busy}, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
